// File: rtl/jtag_tap_param.sv
// jtag_tap_param: IEEE 1149.1-style TAP with generic IR, boundary scan, bypass and optional IDCODE.
// Define JTAG_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_tap_param #(
   parameter int IR_W = 4,
   parameter int BSR_LEN = 8,
   parameter logic [31:0] IDCODE = 32'h0A1B2C3D
) (
   input  logic               TCK,
   input  logic               TRST_N,
   input  logic               TMS,
   input  logic               TDI,
   input  logic [BSR_LEN-1:0] bsr_capture,
   output logic [BSR_LEN-1:0] bsr_update,
   output logic               bsr_mode,
   output logic [IR_W-1:0]    ir_out,
   output logic [3:0]         tap_state,
   output logic               TDO,
   output logic               TDO_EN
);
   typedef enum logic [3:0] {
      TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
      PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
      SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
   } state_t;
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_W-1:0] RST_IR = IR_W'(2);
`else
   localparam logic [IR_W-1:0] RST_IR = '1;
`endif
   state_t state;
   logic [IR_W-1:0] ir_sh;
   logic [BSR_LEN-1:0] bsr_sh;
   logic byp_sh, sel_bsr, sel_id, sel_byp, id_lsb, dr_lsb;
   assign tap_state = state;
   assign bsr_mode = ir_out == '0;
   assign sel_bsr = ir_out == '0 || ir_out == IR_W'(1);
   assign sel_byp = !sel_bsr && !sel_id;
   assign dr_lsb = sel_bsr ? bsr_sh[0] : sel_id ? id_lsb : byp_sh;
`ifdef JTAG_IDCODE_EN
   logic [31:0] id_sh;
   assign sel_id = ir_out == IR_W'(2);
   assign id_lsb = id_sh[0];
   always_ff @(posedge TCK or negedge TRST_N)
      if (!TRST_N) id_sh <= '0;
      else if (state == CAP_DR && sel_id) id_sh <= IDCODE;
      else if (state == SH_DR && sel_id) id_sh <= {TDI, id_sh[31:1]};
`else
   logic unused_id;
   assign unused_id = ^IDCODE;
   assign sel_id = 1'b0;
   assign id_lsb = 1'b0;
`endif
   always_ff @(posedge TCK or negedge TRST_N)
      if (!TRST_N) state <= TLR;
      else
         case (state)
            TLR:                 state <= TMS ? TLR : RTI;
            RTI, UPD_DR, UPD_IR: state <= TMS ? SEL_DR : RTI;
            SEL_DR:              state <= TMS ? SEL_IR : CAP_DR;
            SEL_IR:              state <= TMS ? TLR : CAP_IR;
            CAP_DR, SH_DR:       state <= TMS ? EX1_DR : SH_DR;
            EX1_DR:              state <= TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR:            state <= TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:              state <= TMS ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:       state <= TMS ? EX1_IR : SH_IR;
            EX1_IR:              state <= TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR:            state <= TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:              state <= TMS ? UPD_IR : SH_IR;
            default:             state <= TLR;
         endcase
   always_ff @(posedge TCK or negedge TRST_N)
      if (!TRST_N) begin
         ir_sh <= '0;
         ir_out <= RST_IR;
      end else begin
         if (state == CAP_IR) ir_sh <= IR_W'(1);
         else if (state == SH_IR) ir_sh <= {TDI, ir_sh[IR_W-1:1]};
         if (state == UPD_IR) ir_out <= ir_sh;
         else if (state == TLR) ir_out <= RST_IR;
      end
   // Update latch is left alone in TLR so the pin ring keeps its last driven values.
   always_ff @(posedge TCK or negedge TRST_N)
      if (!TRST_N) begin
         bsr_sh <= '0;
         byp_sh <= 1'b0;
         bsr_update <= '0;
      end else begin
         if (state == CAP_DR && sel_bsr) bsr_sh <= bsr_capture;
         else if (state == SH_DR && sel_bsr) bsr_sh <= (bsr_sh >> 1) | (BSR_LEN'(TDI) << (BSR_LEN - 1));
         if (state == CAP_DR && sel_byp) byp_sh <= 1'b0;
         else if (state == SH_DR && sel_byp) byp_sh <= TDI;
         if (state == UPD_DR && sel_bsr) bsr_update <= bsr_sh;
      end
   always_ff @(negedge TCK or negedge TRST_N)
      if (!TRST_N) begin
         TDO <= 1'b0;
         TDO_EN <= 1'b0;
      end else begin
         TDO_EN <= state == SH_DR || state == SH_IR;
         if (state == SH_IR) TDO <= ir_sh[0];
         else if (state == SH_DR) TDO <= dr_lsb;
      end
endmodule
